// File: rtl/sp_ram_be_if.sv
// Access bundle between the load/store unit and sp_ram_be.
interface sp_ram_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    localparam int BE_W = DATA_W / 8;

    logic              ce;
    logic              oce;
    logic              wre;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              rvalid;

    modport master (
        output ce, oce, wre, be, ad, din,
        input  dout, rvalid
    );

    modport slave (
        input  ce, oce, wre, be, ad, din,
        output dout, rvalid
    );
endinterface

// File: rtl/sp_ram_be.sv
// Single-port block RAM with byte enables, rvalid strobe and
// selectable read latency / write-port read behaviour.
module sp_ram_be #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int READ_MODE  = 0,
    parameter int WRITE_MODE = 0
) (
    input  logic       clk,
    input  logic       reset,
    sp_ram_be_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("sp_ram_be: DATA_W must be a multiple of 8");
    end
    if (READ_MODE != 0 && READ_MODE != 1) begin : g_bad_read_mode
        $error("sp_ram_be: READ_MODE must be 0 or 1");
    end
    if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_write_mode
        $error("sp_ram_be: WRITE_MODE must be 0, 1 or 2");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic              wr_en;
    logic [DATA_W-1:0] s1_d, s1_q;
    logic              v1_d, v1_q;

    assign wr_en    = bus.ce && bus.wre && !reset;
    assign old_word = mem_q[bus.ad];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (bus.be[i]) begin
                merged[8*i +: 8] = bus.din[8*i +: 8];
            end
        end
    end

    // Byte-lane writes keep the array mappable onto byte-enabled BRAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.be[i]) begin
                    mem_q[bus.ad][8*i +: 8] <= bus.din[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        s1_d = s1_q;
        v1_d = 1'b0;
        if (bus.ce) begin
            if (!bus.wre) begin
                s1_d = old_word;
                v1_d = 1'b1;
            end else if (WRITE_MODE == 1) begin
                s1_d = merged;
                v1_d = 1'b1;
            end else if (WRITE_MODE == 2) begin
                s1_d = old_word;
                v1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            v1_q <= v1_d;
        end
    end

    if (READ_MODE == 1) begin : g_pipe
        logic [DATA_W-1:0] s2_d, s2_q;
        logic              v2_d, v2_q;

        // A stage-1 result not taken while oce is low is dropped
        always_comb begin
            s2_d = s2_q;
            v2_d = 1'b0;
            if (bus.oce) begin
                s2_d = s1_q;
                v2_d = v1_q;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s2_q <= '0;
                v2_q <= 1'b0;
            end else begin
                s2_q <= s2_d;
                v2_q <= v2_d;
            end
        end

        assign bus.dout   = s2_q;
        assign bus.rvalid = v2_q;
    end else begin : g_bypass
        logic unused_oce;

        assign unused_oce = bus.oce;
        assign bus.dout   = s1_q;
        assign bus.rvalid = v1_q;
    end
endmodule
